// File: rtl/clk_gen.sv
// Programmable square-wave generator derived from the reference clock `clk`.
// Provides a phase-shift delay, edge strobes and a count of output rising edges.
module clk_gen #(
  parameter int unsigned HALF_PERIOD = 10,
  parameter int unsigned PHASE_SHIFT = 2,
  parameter logic        INIT_LEVEL  = 1'b0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  output logic             clk_out,
  output logic             rise_p,
  output logic             fall_p,
  output logic             phase_done,
  output logic [CNT_W-1:0] period_cnt
);

  if (HALF_PERIOD == 0) begin : g_bad_half_period
    $error("clk_gen: HALF_PERIOD must be at least 1");
  end

  localparam int unsigned MAX_CNT = (HALF_PERIOD > PHASE_SHIFT) ? HALF_PERIOD : PHASE_SHIFT;
  localparam int unsigned DIV_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

  localparam logic [DIV_W-1:0] HP_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] PS_LAST = DIV_W'((PHASE_SHIFT == 0) ? 0 : PHASE_SHIFT - 1);

  typedef enum logic {
    PHASE,
    RUN
  } state_t;

  localparam state_t RST_STATE = (PHASE_SHIFT == 0) ? RUN : PHASE;
  localparam logic   RST_DONE  = (PHASE_SHIFT == 0);

  state_t           state;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cnt        <= '0;
      clk_out    <= INIT_LEVEL;
      rise_p     <= 1'b0;
      fall_p     <= 1'b0;
      phase_done <= RST_DONE;
      period_cnt <= '0;
    end else if (restart) begin
      // Same as reset release, but the rising-edge count survives.
      state      <= RST_STATE;
      cnt        <= '0;
      clk_out    <= INIT_LEVEL;
      rise_p     <= 1'b0;
      fall_p     <= 1'b0;
      phase_done <= RST_DONE;
    end else if (!en) begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
      case (state)
        PHASE: begin
          if (cnt == PS_LAST) begin
            state      <= RUN;
            cnt        <= '0;
            phase_done <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        RUN: begin
          if (cnt == HP_LAST) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            rise_p  <= ~clk_out;
            fall_p  <= clk_out;
            if (!clk_out) begin
              period_cnt <= period_cnt + CNT_W'(1);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gen.sv
// Bench for clk_gen: default instance and a HALF_PERIOD=1/PHASE_SHIFT=0 instance
// share stimulus and are compared each cycle against an edge-count reference model.
module tb_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;

  logic        clk_out0, rise0, fall0, done0;
  logic [15:0] pc0;
  logic        clk_out1, rise1, fall1, done1;
  logic [15:0] pc1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  clk_gen dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .restart    (restart),
    .clk_out    (clk_out0),
    .rise_p     (rise0),
    .fall_p     (fall0),
    .phase_done (done0),
    .period_cnt (pc0)
  );

  clk_gen #(
    .HALF_PERIOD (1),
    .PHASE_SHIFT (0)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .restart    (restart),
    .clk_out    (clk_out1),
    .rise_p     (rise1),
    .fall_p     (fall1),
    .phase_done (done1),
    .period_cnt (pc1)
  );

  // Reference model: counting edges since reset/restart determine everything.
  localparam int unsigned HP_M [2] = '{10, 1};
  localparam int unsigned PS_M [2] = '{2, 0};

  int unsigned mk    [2];
  int unsigned mbase [2];
  logic        mrise [2];
  logic        mfall [2];

  function automatic int unsigned toggles(input int unsigned k, input int unsigned hp,
                                          input int unsigned ps);
    if (k < ps + hp) return 0;
    return (k - ps) / hp;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      mk[i] = 0; mbase[i] = 0; mrise[i] = 1'b0; mfall[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic e, input logic r);
    for (int unsigned i = 0; i < 2; i++) begin
      int unsigned t0, t1;
      t0 = toggles(mk[i], HP_M[i], PS_M[i]);
      mrise[i] = 1'b0;
      mfall[i] = 1'b0;
      if (r) begin
        mbase[i] += (t0 + 1) / 2;
        mk[i] = 0;
      end else if (e) begin
        mk[i]++;
        t1 = toggles(mk[i], HP_M[i], PS_M[i]);
        if (t1 != t0) begin
          if (t1 % 2 == 1) mrise[i] = 1'b1;
          else             mfall[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_inst(input int unsigned i, input logic co, input logic ri,
                              input logic fa, input logic pd, input logic [15:0] pc);
    int unsigned t;
    t = toggles(mk[i], HP_M[i], PS_M[i]);
    check($sformatf("i%0d_clk_out", i), 32'(co), 32'(t % 2));
    check($sformatf("i%0d_rise_p", i), 32'(ri), 32'(mrise[i]));
    check($sformatf("i%0d_fall_p", i), 32'(fa), 32'(mfall[i]));
    check($sformatf("i%0d_phase_done", i), 32'(pd), 32'(mk[i] >= PS_M[i]));
    check($sformatf("i%0d_period_cnt", i), 32'(pc), 32'(16'(mbase[i] + (t + 1) / 2)));
    check($sformatf("i%0d_both_strobes", i), 32'(ri & fa), 32'd0);
  endtask

  task automatic compare_all();
    compare_inst(0, clk_out0, rise0, fall0, done0, pc0);
    compare_inst(1, clk_out1, rise1, fall1, done1, pc1);
  endtask

  task automatic step(input logic e, input logic r);
    en      = e;
    restart = r;
    @(posedge clk);
    model_edge(e, r);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_clk_out0", 32'(clk_out0), 32'd0);
    check("rst_strobes0", 32'({rise0, fall0}), 32'd0);
    check("rst_done0", 32'(done0), 32'd0);
    check("rst_done1", 32'(done1), 32'd1);
    check("rst_pc0", 32'(pc0), 32'd0);
    compare_all();
    en      = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_default60(input string tag);
    for (int unsigned i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0);
      if (i == 1) begin
        check({tag, "_done_e1"}, 32'(done0), 32'd0);
        check({tag, "_i1_clk_e1"}, 32'(clk_out1), 32'd1);
      end
      if (i == 2) begin
        check({tag, "_done_e2"}, 32'(done0), 32'd1);
        check({tag, "_i1_clk_e2"}, 32'(clk_out1), 32'd0);
      end
      if (i == 11) check({tag, "_clk_e11"}, 32'(clk_out0), 32'd0);
      if (i == 12) check({tag, "_rise_e12"}, 32'({clk_out0, rise0, fall0}), 32'b110);
      if (i == 22) check({tag, "_fall_e22"}, 32'({clk_out0, rise0, fall0}), 32'b001);
      if (i == 32) check({tag, "_rise_e32"}, 32'({clk_out0, rise0}), 32'b11);
      if (i == 42) check({tag, "_fall_e42"}, 32'({clk_out0, fall0}), 32'b01);
      if (i == 52) begin
        check({tag, "_rise_e52"}, 32'({clk_out0, rise0}), 32'b11);
        check({tag, "_pc_e52"}, 32'(pc0), 32'd3);
      end
    end
  endtask

  initial begin
    model_reset();
    async_reset();

    run_default60("s1");

    // Reset in the middle of a high phase, then the first run again.
    async_reset();
    for (int unsigned i = 1; i <= 15; i++) step(1'b1, 1'b0);
    check("mid_high_before_rst", 32'(clk_out0), 32'd1);
    async_reset();
    run_default60("s2");

    // Restart at edge 25 with clk_out low.
    async_reset();
    for (int unsigned i = 1; i <= 24; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("rs_clk_out", 32'(clk_out0), 32'd0);
    check("rs_pc_kept", 32'(pc0), 32'd1);
    check("rs_no_strobe", 32'({rise0, fall0, rise1, fall1}), 32'd0);
    for (int unsigned j = 1; j <= 12; j++) begin
      step(1'b1, 1'b0);
      if (j == 11) check("rs_clk_e11", 32'(clk_out0), 32'd0);
      if (j == 12) check("rs_rise_e12", 32'({clk_out0, rise0, pc0}), 32'({1'b1, 1'b1, 16'd2}));
    end

    // Enable held low for five cycles after edge 15.
    async_reset();
    for (int unsigned raw = 1; raw <= 30; raw++) begin
      logic hold;
      hold = (raw >= 16) && (raw <= 20);
      step(!hold, 1'b0);
      if (hold) check("hold_clk_high", 32'({clk_out0, rise0, fall0}), 32'b100);
      if (raw == 26) check("hold_clk_e26", 32'(clk_out0), 32'd1);
      if (raw == 27) check("hold_fall_e27", 32'({clk_out0, fall0}), 32'b01);
    end

    // Randomized enable/restart traffic with occasional asynchronous resets.
    for (int unsigned n = 0; n < 3000; n++) begin
      logic e, r;
      e = ($urandom_range(0, 99) < 85);
      r = ($urandom_range(0, 99) < 2);
      step(e, r);
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
